// File: rtl/pio_input_capture_pkg.sv
// Shared constants for the input-capture PIO: register word addresses and
// edge-type encodings.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_input_capture_if.sv
// Avalon-MM slave bus bundle for the input-capture PIO.
interface pio_input_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_input_capture_sync_edge.sv
// Input synchronizer, previous-value register, warm-up counter and per-bit
// edge pulse generation.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = EDGE_FALL,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0]  chain [SYNC_STAGES];
  logic [WIDTH-1:0]  prev;
  logic [WARM_W-1:0] warm;
  logic [WIDTH-1:0]  detect;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
      warm <= WARM_W'(SYNC_STAGES + 1);
    end else begin
      chain[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= sync;
      if (warm != '0) warm <= warm - 1'b1;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  // Warm-up covers the chain filling from its reset value of 0, so input
  // levels already present at reset release never register as edges.
  always_comb begin
    detect = sync ^ prev;
    if (EDGE_TYPE == EDGE_RISE)      detect = sync & ~prev;
    else if (EDGE_TYPE == EDGE_FALL) detect = ~sync & prev;
    edge_pulse = (warm == '0) ? detect : '0;
  end

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: synchronized level readback, edge capture register
// with write-1-to-clear, and a maskable registered level interrupt.
module pio_input_capture
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EDGE_TYPE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  pio_input_capture_if.slave     bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;
  logic             rd_en;
  logic             wr_en;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .sync      (sync),
    .edge_pulse(edge_pulse)
  );

  assign rd_en        = bus.chipselect && !bus.read_n;
  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    clr = '0;
    if (wr_en && bus.address == ADDR_EDGE) clr = bus.writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA: rd_word[WIDTH-1:0] = sync;
      ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_word[WIDTH-1:0] = edge_capture;
      default:   rd_word = '0;
    endcase
  end

  // Set is ORed in after the clear so a same-cycle edge beats the W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | edge_pulse;
      if (rd_en) bus.readdata <= rd_word;
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_pio_input_capture.sv
// Scoreboard bench for pio_input_capture: a falling-edge instance carries the
// main scenarios, a rising-edge instance covers warm-up suppression.
module tb_pio_input_capture;
  import pio_pkg::*;

  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    addr;
  logic          cs, rd_n, wr_n;
  logic [31:0]   wdata;
  logic [W-1:0]  in_f, in_r;
  logic          irq_f, irq_r;

  pio_input_capture_if bus_f();
  pio_input_capture_if bus_r();

  assign bus_f.address    = addr;
  assign bus_f.chipselect = cs;
  assign bus_f.read_n     = rd_n;
  assign bus_f.write_n    = wr_n;
  assign bus_f.writedata  = wdata;
  assign bus_r.address    = addr;
  assign bus_r.chipselect = cs;
  assign bus_r.read_n     = rd_n;
  assign bus_r.write_n    = wr_n;
  assign bus_r.writedata  = wdata;

  pio_input_capture #(.WIDTH(W), .EDGE_TYPE(EDGE_FALL), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset(reset), .bus(bus_f), .in_port(in_f), .irq(irq_f)
  );

  pio_input_capture #(.WIDTH(W), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset(reset), .bus(bus_r), .in_port(in_r), .irq(irq_r)
  );

  typedef struct {
    logic [31:0] exp;
    bit          sel_r;
    string       name;
  } rd_t;

  rd_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [1:0] a, input bit r, input logic [31:0] exp, input string name);
    addr = a; cs = 1'b1; rd_n = 1'b0;
    sb.push_back('{exp, r, name});
    @(posedge clk); #1;
    cs = 1'b0; rd_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; cs = 1'b1; wr_n = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; wr_n = 1'b1;
  endtask

  // Monitor: a strobe seen at an edge is compared on the following negedge.
  initial begin
    forever begin
      @(posedge clk);
      if (cs && !rd_n) begin
        rd_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got 0x%08h expected no read", bus_f.readdata);
        end else begin
          e = sb.pop_front();
          chk(e.name, e.sel_r ? bus_r.readdata : bus_f.readdata, e.exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = '0; wdata = '0;
    in_f = 4'hF; in_r = 4'hF;
    idle(3);
    chk("reset_irq_f", 32'(irq_f), 32'h0);
    chk("reset_irq_r", 32'(irq_r), 32'h0);
    chk("reset_readdata_f", bus_f.readdata, 32'h0);
    reset = 1'b0;

    // 1: inputs high through reset release produce no capture
    idle(6);
    rd(ADDR_EDGE, 1'b1, 32'h0, "t1_rise_edge_warmup");
    rd(ADDR_DATA, 1'b1, 32'hF, "t1_rise_data");
    rd(ADDR_EDGE, 1'b0, 32'h0, "t1_fall_edge");
    chk("t1_irq_r", 32'(irq_r), 32'h0);

    // 2: falling edge on bit 2, exact capture latency, irq set and clear
    in_f = 4'b1011;
    for (int i = 0; i < S + 2; i++)
      rd(ADDR_EDGE, 1'b0, (i == S + 1) ? 32'h4 : 32'h0, "t2_edge_timing");
    wr(ADDR_MASK, 32'h4);
    chk("t2_irq_not_yet", 32'(irq_f), 32'h0);
    idle(1);
    chk("t2_irq_set", 32'(irq_f), 32'h1);
    wr(ADDR_EDGE, 32'h4);
    chk("t2_irq_still", 32'(irq_f), 32'h1);
    idle(1);
    chk("t2_irq_clear", 32'(irq_f), 32'h0);
    rd(ADDR_EDGE, 1'b0, 32'h0, "t2_edge_cleared");

    // 3: read latency, hold, reserved address
    wr(ADDR_MASK, 32'hA);
    rd(ADDR_MASK, 1'b0, 32'hA, "t3_mask_read");
    idle(1);
    chk("t3_readdata_hold", bus_f.readdata, 32'hA);
    rd(ADDR_RSVD, 1'b0, 32'h0, "t3_rsvd_read");
    wr(ADDR_RSVD, 32'hFFFF_FFFF);
    rd(ADDR_RSVD, 1'b0, 32'h0, "t3_rsvd_after_write");
    rd(ADDR_MASK, 1'b1, 32'hA, "t3_mask_read_r");

    // 4: falling edge on bit 0 captured in the same cycle as its W1C
    in_f = 4'b1010;
    idle(S);
    wr(ADDR_EDGE, 32'h1);
    rd(ADDR_EDGE, 1'b0, 32'h1, "t4_collision");

    // 5: fill capture, partial clear, data write ignored
    in_f = 4'hF; in_r = 4'h0;
    idle(4);
    in_f = 4'h0; in_r = 4'hF;
    idle(4);
    rd(ADDR_EDGE, 1'b0, 32'hF, "t5_edge_full_f");
    rd(ADDR_EDGE, 1'b1, 32'hF, "t5_edge_full_r");
    wr(ADDR_EDGE, 32'h5);
    rd(ADDR_EDGE, 1'b0, 32'hA, "t5_partial_f");
    rd(ADDR_EDGE, 1'b1, 32'hA, "t5_partial_r");
    in_f = 4'h5;
    idle(4);
    rd(ADDR_DATA, 1'b0, 32'h5, "t5_data");
    wr(ADDR_DATA, 32'hFFFF_FFFF);
    rd(ADDR_DATA, 1'b0, 32'h5, "t5_data_after_write");
    rd(ADDR_EDGE, 1'b0, 32'hA, "t5_rise_ignored");
    chk("t6_irq_pre", 32'(irq_f), 32'h1);

    // 6: reset during a read, then a toggle inside the warm-up window
    in_r = 4'h0;
    idle(4);
    reset = 1'b1; addr = ADDR_EDGE; cs = 1'b1; rd_n = 1'b0;
    sb.push_back('{32'h0, 1'b0, "t6_read_in_reset"});
    @(posedge clk); #1;
    cs = 1'b0; rd_n = 1'b1; reset = 1'b0; in_r = 4'hF;
    chk("t6_irq_f_reset", 32'(irq_f), 32'h0);
    chk("t6_irq_r_reset", 32'(irq_r), 32'h0);
    idle(5);
    rd(ADDR_EDGE, 1'b0, 32'h0, "t6_edge_f");
    rd(ADDR_MASK, 1'b0, 32'h0, "t6_mask_f");
    rd(ADDR_EDGE, 1'b1, 32'h0, "t6_warmup_suppressed");
    rd(ADDR_DATA, 1'b1, 32'hF, "t6_data_r");
    in_r = 4'h0;
    idle(4);
    in_r = 4'hF;
    idle(4);
    rd(ADDR_EDGE, 1'b1, 32'hF, "t6_live_after_warmup");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending reads expected 0", sb.size());
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pio_input_capture.md
Name: pio_input_capture

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the 7-bit output PIOs driving the HEX displays.
- Samples an external asynchronous input bus (KEY/SW) through a synchronizer and exposes its level on the bus.
- Latches per-bit edge events into a capture register and raises a maskable level interrupt to the Nios II.
- Sits in unsaved_subsystemA beside the HEX PIOs on the same Avalon interconnect.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- EDGE_TYPE, 1, 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2, synchronizer flops per bit (2..4).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address within the slave.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, valid one cycle after the read strobe.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: the sync chain, edge-detect previous-value register, irq_mask, edge_capture, readdata and irq are all 0. The warm-up counter is loaded with SYNC_STAGES+1.
- Register map (word address):
  - 0: data, read-only; the synchronized level.
  - 1: reserved; reads 0, writes ignored.
  - 2: irq_mask, read/write, WIDTH bits.
  - 3: edge_capture, read; write-1-to-clear per bit.
- Unused readdata bits read 0.
- Reads:
  - readdata is registered and loaded when chipselect && !read_n; read latency is 1 with no wait states.
  - When no read is strobed, readdata holds its previous value.
  - A read has no side effects; reading edge_capture does not clear it.
- Writes:
  - A write takes effect when chipselect && !write_n and is visible on the following cycle.
  - Writes to address 0 or 1 are ignored.
- Synchronizer:
  - in_port passes through SYNC_STAGES flops to produce sync.
  - A previous-value register prev samples sync every cycle.
  - Input-to-data latency is SYNC_STAGES cycles.
- Edge detection, per bit:
  - rising = sync & ~prev.
  - falling = ~sync & prev.
  - any = sync ^ prev.
  - EDGE_TYPE selects which of the three is used.
- Warm-up:
  - Edge detection is suppressed while the warm-up counter is nonzero.
  - The counter decrements by 1 each cycle after reset and saturates at 0.
  - This prevents spurious captures from input levels present at reset release.
- edge_capture update, per bit:
  - An edge sets the bit.
  - A write of 1 to that bit at address 3 clears it.
  - When an edge and a W1C clear hit the same bit in the same cycle, the set wins (the bit stays 1).
  - Other bits are unaffected by a write of 0.
- irq:
  - Registered: irq <= |(edge_capture & irq_mask).
  - irq asserts one cycle after the capture bit and the mask bit are both 1.
  - irq deasserts one cycle after the clear or unmask.
- Reset mid-operation: reset returns all state to reset values on the next edge, including an in-flight read (readdata becomes 0) and a restarted warm-up.
- Simultaneous read and write: allowed; the read returns the pre-write value.

Decomposition:
- Shared package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3;
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One natural sub-module, pio_sync_edge: synchronizer, prev register, warm-up counter, and an edge-pulse output of WIDTH bits.
- The top level holds the register file, the read mux and irq.

Test Plan:
1. Reset with in_port=4'b1111 held, EDGE_TYPE=0 -> after warm-up, edge_capture=0, irq=0, and a read of address 0 returns 0x0000000F.
2. EDGE_TYPE=1: drive bit 2 from 1 to 0 and hold -> edge_capture=0x4 exactly SYNC_STAGES+1 cycles later. Write mask=0x4 -> irq=1 the next cycle. Write 0x4 to address 3 -> edge_capture=0 and irq=0 one cycle later.
3. Read latency check: read of address 2 after mask=0xA -> readdata=0x0000000A on the cycle after the strobe. Reads of address 1 return 0.
4. Collision: a falling edge on bit 0 lands in the same cycle as a W1C write of 0x1 -> bit 0 remains 1.
5. Partial clear: edge_capture=0xF, write 0x5 to address 3 -> edge_capture=0xA. A write to address 0 leaves data unchanged.
6. Assert reset mid-read with irq=1 -> next cycle readdata=0, irq=0, mask=0, capture=0. A toggle during warm-up is not captured.
